// File: rtl/axi4_pkg.sv
// Shared AXI4 types and constants for the SRAM slave: burst and response encodings,
// channel field widths and FSM state codes.
package axi4_pkg;

   localparam int AXI_LEN_W  = 8;
   localparam int AXI_SIZE_W = 3;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_t;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_t;

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_WR_DATA = 3'd1;
   localparam state_t ST_WR_RESP = 3'd2;
   localparam state_t ST_RD_ADDR = 3'd3;
   localparam state_t ST_RD_DATA = 3'd4;

   // WRAP bursts are only legal with 2, 4, 8 or 16 beats
   function automatic logic wrap_len_ok(input logic [AXI_LEN_W-1:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
// Callers pass an already-legalised burst type (reserved/illegal WRAP mapped to INCR).
module axi4_burst_addr_gen
   import axi4_pkg::*;
#(
   parameter int ADDR_W = 32
)
(
   input  logic [ADDR_W-1:0]     addr,
   input  logic [AXI_LEN_W-1:0]  len,
   input  logic [AXI_SIZE_W-1:0] size,
   input  logic [1:0]            burst,
   output logic [ADDR_W-1:0]     next_addr
);

   logic [ADDR_W-1:0] step;
   logic [ADDR_W-1:0] incr_addr;
   logic [ADDR_W-1:0] wrap_mask;

   // The wrap window is (len+1) transfers wide; the address stays inside the aligned window
   always_comb begin
      step      = ADDR_W'(1) << size;
      incr_addr = addr + step;
      wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
      case (burst)
         BURST_FIXED: next_addr = addr;
         BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
         default:     next_addr = incr_addr;
      endcase
   end

endmodule

// File: rtl/axi4_sram_slave.sv
// AXI4 slave serving one burst at a time from an internal word-addressed SRAM.
// Define AXI4_SLV_RANGE_CHK_EN to flag beats beyond the SRAM as SLVERR instead of aliasing.
module axi4_sram_slave
   import axi4_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 8,
   parameter int WORDS  = 1024
)
(
   input  logic                  ACLK,
   input  logic                  ARESETn,
   input  logic [ID_W-1:0]       AWID,
   input  logic [ADDR_W-1:0]     AWADDR,
   input  logic [7:0]            AWLEN,
   input  logic [2:0]            AWSIZE,
   input  logic [1:0]            AWBURST,
   input  logic                  AWVALID,
   output logic                  AWREADY,
   input  logic [DATA_W-1:0]     WDATA,
   input  logic [DATA_W/8-1:0]   WSTRB,
   input  logic                  WLAST,
   input  logic                  WVALID,
   output logic                  WREADY,
   output logic [ID_W-1:0]       BID,
   output logic [1:0]            BRESP,
   output logic                  BVALID,
   input  logic                  BREADY,
   input  logic [ID_W-1:0]       ARID,
   input  logic [ADDR_W-1:0]     ARADDR,
   input  logic [7:0]            ARLEN,
   input  logic [2:0]            ARSIZE,
   input  logic [1:0]            ARBURST,
   input  logic                  ARVALID,
   output logic                  ARREADY,
   output logic [ID_W-1:0]       RID,
   output logic [DATA_W-1:0]     RDATA,
   output logic [1:0]            RRESP,
   output logic                  RLAST,
   output logic                  RVALID,
   input  logic                  RREADY
);

   localparam int STRB_W = DATA_W / 8;
   localparam int LSB    = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(WORDS);

   state_t                state;
   logic                  rd_prio;
   logic                  err;
   logic [ID_W-1:0]       id_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [ADDR_W-1:0]     next_addr;
   logic [AXI_LEN_W-1:0]  len_q;
   logic [AXI_LEN_W-1:0]  beat_cnt;
   logic [AXI_SIZE_W-1:0] size_q;
   logic [1:0]            burst_q;
   logic [DATA_W-1:0]     rdata_q;
   logic [DATA_W-1:0]     mem [WORDS];
   logic [IDX_W-1:0]      word_idx;

   logic                  aw_hs, ar_hs, w_hs, last_beat, beat_range_err;
   logic [ID_W-1:0]       a_id;
   logic [ADDR_W-1:0]     a_addr;
   logic [AXI_LEN_W-1:0]  a_len;
   logic [AXI_SIZE_W-1:0] a_size;
   logic [1:0]            a_burst;
   logic [1:0]            eff_burst;
   logic                  wrap_bad, req_err;

   assign AWREADY = ARESETn && (state == ST_IDLE) && !(ARVALID && rd_prio);
   assign ARREADY = ARESETn && (state == ST_IDLE) && ARVALID && (rd_prio || !AWVALID);
   assign aw_hs   = AWVALID && AWREADY;
   assign ar_hs   = ARVALID && ARREADY;
   assign w_hs    = WVALID && WREADY;

   assign WREADY  = (state == ST_WR_DATA);
   assign BVALID  = (state == ST_WR_RESP);
   assign BID     = id_q;
   assign BRESP   = err ? RESP_SLVERR : RESP_OKAY;
   assign RVALID  = (state == ST_RD_DATA);
   assign RID     = id_q;
   assign RDATA   = rdata_q;
   assign RRESP   = err ? RESP_SLVERR : RESP_OKAY;
   assign RLAST   = RVALID && last_beat;

   assign last_beat = (beat_cnt == len_q);
   assign word_idx  = IDX_W'(addr_q >> LSB);

`ifdef AXI4_SLV_RANGE_CHK_EN
   localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(WORDS * STRB_W);
   assign beat_range_err = (addr_q >= MEM_BYTES);
`else
   assign beat_range_err = 1'b0;
`endif

   assign a_id    = ar_hs ? ARID    : AWID;
   assign a_addr  = ar_hs ? ARADDR  : AWADDR;
   assign a_len   = ar_hs ? ARLEN   : AWLEN;
   assign a_size  = ar_hs ? ARSIZE  : AWSIZE;
   assign a_burst = ar_hs ? ARBURST : AWBURST;

   // Malformed requests are still executed (illegal bursts as INCR) but answered with SLVERR
   always_comb begin
      wrap_bad  = (a_burst == BURST_WRAP) && !wrap_len_ok(a_len);
      req_err   = (a_size > AXI_SIZE_W'(LSB)) || (a_burst == BURST_RSVD) || wrap_bad;
      eff_burst = ((a_burst == BURST_RSVD) || wrap_bad) ? BURST_INCR : a_burst;
   end

   axi4_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .addr      (addr_q),
      .len       (len_q),
      .size      (size_q),
      .burst     (burst_q),
      .next_addr (next_addr)
   );

   // Burst sequencing; the beat count alone ends a write burst, WLAST only feeds the error flag
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state    <= ST_IDLE;
         rd_prio  <= 1'b0;
         err      <= 1'b0;
         id_q     <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         size_q   <= '0;
         burst_q  <= BURST_FIXED;
         beat_cnt <= '0;
         rdata_q  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (aw_hs || ar_hs) begin
                  rd_prio  <= !rd_prio;
                  id_q     <= a_id;
                  addr_q   <= a_addr;
                  len_q    <= a_len;
                  size_q   <= a_size;
                  burst_q  <= eff_burst;
                  err      <= req_err;
                  beat_cnt <= '0;
                  state    <= ar_hs ? ST_RD_ADDR : ST_WR_DATA;
               end
            end
            ST_WR_DATA: begin
               if (WVALID) begin
                  if (beat_range_err || (WLAST != last_beat))
                     err <= 1'b1;
                  if (last_beat) begin
                     state <= ST_WR_RESP;
                  end else begin
                     beat_cnt <= beat_cnt + AXI_LEN_W'(1);
                     addr_q   <= next_addr;
                  end
               end
            end
            ST_WR_RESP: begin
               if (BREADY)
                  state <= ST_IDLE;
            end
            ST_RD_ADDR: begin
               rdata_q <= beat_range_err ? '0 : mem[word_idx];
               if (beat_range_err)
                  err <= 1'b1;
               state <= ST_RD_DATA;
            end
            ST_RD_DATA: begin
               if (RREADY) begin
                  if (last_beat) begin
                     state <= ST_IDLE;
                  end else begin
                     beat_cnt <= beat_cnt + AXI_LEN_W'(1);
                     addr_q   <= next_addr;
                     state    <= ST_RD_ADDR;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // SRAM array has no reset; only strobed lanes of in-range beats are written
   always_ff @(posedge ACLK) begin
      if (w_hs && !beat_range_err) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (WSTRB[b])
               mem[word_idx][b*8 +: 8] <= WDATA[b*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Scoreboard bench for axi4_sram_slave: a byte-level memory model predicts every B and R beat,
// and a negedge monitor compares whatever the DUT hands over against the queued predictions.
module tb_axi4_sram_slave;

   localparam int TIMEOUT = 200;

   logic        ACLK = 1'b0;
   logic        ARESETn;
   logic [7:0]  AWID, ARID, BID, RID;
   logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
   logic [7:0]  AWLEN, ARLEN;
   logic [2:0]  AWSIZE, ARSIZE;
   logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
   logic [3:0]  WSTRB;
   logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

   always #5 ACLK = ~ACLK;

   axi4_sram_slave dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   typedef struct { logic [7:0] id; logic [1:0] resp; } b_exp_t;
   typedef struct { logic [7:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

   int          checks = 0;
   int          errors = 0;
   int          grants = 0;
   int          bad_last_beat = -1;
   b_exp_t      bq[$];
   r_exp_t      rq[$];
   b_exp_t      b_cur;
   r_exp_t      r_cur;
   logic [31:0] model_mem [1024];
   logic [31:0] wdata_buf [256];
   logic [3:0]  wstrb_buf [256];

   task automatic check_output(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: no handshake within %0d cycles, expected one", name, TIMEOUT);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   endtask

   // Reference model: spec rules expressed as plain arithmetic on byte addresses
   function automatic logic burst_err(int len, int size, int burst);
      return (size > 2) || (burst == 3) || (burst == 2 && !(len inside {1, 3, 7, 15}));
   endfunction

   function automatic logic [31:0] beat_addr(logic [31:0] start, int len, int size, int burst, int i);
      logic [31:0] incr = 32'd1 << size;
      logic [31:0] span = 32'(len + 1) * incr;
      logic [31:0] base = start - (start % span);
      logic [31:0] res;
      int          eff = burst;
      if (burst == 3 || (burst == 2 && !(len inside {1, 3, 7, 15}))) eff = 1;
      if (eff == 0)      res = start;
      else if (eff == 2) res = base + ((start - base + 32'(i) * incr) % span);
      else               res = start + 32'(i) * incr;
      return res;
   endfunction

   function automatic logic in_range(logic [31:0] a);
`ifdef AXI4_SLV_RANGE_CHK_EN
      return a < 32'd4096;
`else
      return (a == a);
`endif
   endfunction

   function automatic logic wlast_for(int i, int len);
      return (bad_last_beat >= 0) ? (i == bad_last_beat) : (i == len);
   endfunction

   task automatic model_write(logic [7:0] id, logic [31:0] addr, int len, int size, int burst);
      logic err = burst_err(len, size, burst);
      for (int i = 0; i <= len; i++) begin
         logic [31:0] a = beat_addr(addr, len, size, burst, i);
         if (wlast_for(i, len) != (i == len)) err = 1'b1;
         if (!in_range(a)) err = 1'b1;
         else
            for (int b = 0; b < 4; b++)
               if (wstrb_buf[i][b]) model_mem[a[11:2]][b*8 +: 8] = wdata_buf[i][b*8 +: 8];
      end
      bq.push_back('{id, err ? 2'b10 : 2'b00});
   endtask

   task automatic model_read(logic [7:0] id, logic [31:0] addr, int len, int size, int burst);
      logic err = burst_err(len, size, burst);
      for (int i = 0; i <= len; i++) begin
         logic [31:0] a = beat_addr(addr, len, size, burst, i);
         logic [31:0] d;
         if (!in_range(a)) begin
            err = 1'b1;
            d   = 32'h0;
         end else begin
            d = model_mem[a[11:2]];
         end
         rq.push_back('{id, d, err ? 2'b10 : 2'b00, (i == len)});
      end
   endtask

   // Monitor: every completed B or R handshake is matched against the oldest prediction
   always @(negedge ACLK) begin
      if (ARESETn) begin
         if (BVALID && BREADY) begin
            if (bq.size() == 0) begin
               check_output("b_unexpected", 64'(bq.size()), 64'd1);
            end else begin
               b_cur = bq.pop_front();
               check_output("bid", 64'(BID), 64'(b_cur.id));
               check_output("bresp", 64'(BRESP), 64'(b_cur.resp));
            end
         end
         if (RVALID && RREADY) begin
            if (rq.size() == 0) begin
               check_output("r_unexpected", 64'(rq.size()), 64'd1);
            end else begin
               r_cur = rq.pop_front();
               check_output("rid", 64'(RID), 64'(r_cur.id));
               check_output("rdata", 64'(RDATA), 64'(r_cur.data));
               check_output("rresp", 64'(RRESP), 64'(r_cur.resp));
               check_output("rlast", 64'(RLAST), 64'(r_cur.last));
            end
         end
      end
   end

   // Drivers are entered and left 1 time unit after a rising edge
   task automatic wait_hs(string name, int which);
      int n = 0;
      forever begin
         @(negedge ACLK);
         if ((which == 0 && AWVALID && AWREADY) || (which == 1 && WVALID && WREADY) ||
             (which == 2 && BVALID && BREADY) || (which == 3 && ARVALID && ARREADY) ||
             (which == 4 && RVALID && RREADY))
            break;
         n++;
         if (n > TIMEOUT) timeout_fail(name);
      end
      @(posedge ACLK);
      #1;
   endtask

   task automatic set_aw(logic [7:0] id, logic [31:0] addr, int len, int size, int burst);
      AWID = id; AWADDR = addr; AWLEN = 8'(len); AWSIZE = 3'(size); AWBURST = 2'(burst);
   endtask

   task automatic set_ar(logic [7:0] id, logic [31:0] addr, int len, int size, int burst);
      ARID = id; ARADDR = addr; ARLEN = 8'(len); ARSIZE = 3'(size); ARBURST = 2'(burst);
   endtask

   task automatic w_phase(int len);
      for (int i = 0; i <= len; i++) begin
         WVALID = 1'b0;
         repeat ($urandom_range(0, 1)) begin @(posedge ACLK); #1; end
         WDATA = wdata_buf[i]; WSTRB = wstrb_buf[i]; WLAST = wlast_for(i, len); WVALID = 1'b1;
         wait_hs("w_hs", 1);
      end
      WVALID = 1'b0;
      WLAST  = 1'b0;
   endtask

   task automatic b_phase(int delay);
      repeat (delay) begin @(posedge ACLK); #1; end
      BREADY = 1'b1;
      wait_hs("b_hs", 2);
      BREADY = 1'b0;
   endtask

   task automatic r_phase(int len, int hold);
      for (int i = 0; i <= len; i++) begin
         RREADY = 1'b0;
         if (i == 0 && hold > 0) begin
            int n = 0;
            forever begin
               @(negedge ACLK);
               if (RVALID) break;
               n++;
               if (n > TIMEOUT) timeout_fail("rvalid_wait");
            end
            for (int k = 0; k < hold; k++) begin
               check_output("stall_rvalid", 64'(RVALID), 64'd1);
               check_output("stall_rdata", 64'(RDATA), 64'(rq[0].data));
               check_output("stall_rlast", 64'(RLAST), 64'(rq[0].last));
               @(posedge ACLK); #1;
               @(negedge ACLK);
            end
            @(posedge ACLK); #1;
         end else begin
            repeat ($urandom_range(0, 1)) begin @(posedge ACLK); #1; end
         end
         RREADY = 1'b1;
         wait_hs("r_hs", 4);
      end
      RREADY = 1'b0;
   endtask

   task automatic apply_write(logic [7:0] id, logic [31:0] addr, int len, int size, int burst, int bdelay);
      model_write(id, addr, len, size, burst);
      set_aw(id, addr, len, size, burst);
      AWVALID = 1'b1;
      wait_hs("aw_hs", 0);
      grants++;
      AWVALID = 1'b0;
      w_phase(len);
      b_phase(bdelay);
   endtask

   task automatic apply_read(logic [7:0] id, logic [31:0] addr, int len, int size, int burst, int hold);
      model_read(id, addr, len, size, burst);
      set_ar(id, addr, len, size, burst);
      ARVALID = 1'b1;
      wait_hs("ar_hs", 3);
      grants++;
      ARVALID = 1'b0;
      r_phase(len, hold);
   endtask

   task automatic fill_buffers(int len, logic full_strb);
      for (int i = 0; i <= len; i++) begin
         wdata_buf[i] = $urandom;
         wstrb_buf[i] = full_strb ? 4'hF : 4'($urandom);
      end
   endtask

   // AW and AR presented together: the grant alternates, starting with write after reset
   task automatic both_valid(logic [31:0] addr, int hold);
      logic wr_first = (grants % 2) == 0;
      fill_buffers(1, 1'b1);
      if (wr_first) begin
         model_write(8'hA1, addr, 1, 2, 1);
         model_read(8'hB2, addr, 1, 2, 1);
      end else begin
         model_read(8'hB2, addr, 1, 2, 1);
         model_write(8'hA1, addr, 1, 2, 1);
      end
      set_aw(8'hA1, addr, 1, 2, 1);
      set_ar(8'hB2, addr, 1, 2, 1);
      AWVALID = 1'b1;
      ARVALID = 1'b1;
      @(negedge ACLK);
      check_output("arb_awready", 64'(AWREADY), 64'(wr_first));
      check_output("arb_arready", 64'(ARREADY), 64'(!wr_first));
      @(posedge ACLK); #1;
      grants++;
      if (wr_first) begin
         AWVALID = 1'b0;
         @(negedge ACLK);
         check_output("arb_ar_blocked", 64'(ARREADY), 64'd0);
         @(posedge ACLK); #1;
         w_phase(1);
         b_phase(0);
         wait_hs("ar_hs", 3);
         grants++;
         ARVALID = 1'b0;
         r_phase(1, hold);
      end else begin
         ARVALID = 1'b0;
         r_phase(1, hold);
         wait_hs("aw_hs", 0);
         grants++;
         AWVALID = 1'b0;
         w_phase(1);
         b_phase(0);
      end
   endtask

   task automatic check_reset_outputs(string tag);
      check_output({tag, "_awready"}, 64'(AWREADY), 64'd0);
      check_output({tag, "_arready"}, 64'(ARREADY), 64'd0);
      check_output({tag, "_bvalid"}, 64'(BVALID), 64'd0);
      check_output({tag, "_rvalid"}, 64'(RVALID), 64'd0);
      check_output({tag, "_rlast"}, 64'(RLAST), 64'd0);
      check_output({tag, "_rdata"}, 64'(RDATA), 64'd0);
      check_output({tag, "_rid"}, 64'(RID), 64'd0);
      check_output({tag, "_bid"}, 64'(BID), 64'd0);
      check_output({tag, "_bresp"}, 64'(BRESP), 64'd0);
      check_output({tag, "_rresp"}, 64'(RRESP), 64'd0);
   endtask

   initial begin
      int cnt;
      ARESETn = 1'b0;
      AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;
      WLAST = 1'b0; WDATA = '0; WSTRB = '0;
      set_aw(8'h0, 32'h0, 0, 2, 1);
      set_ar(8'h0, 32'h0, 0, 2, 1);
      #2;
      check_reset_outputs("por");
      repeat (2) @(posedge ACLK);
      #1;
      ARESETn = 1'b1;
      @(negedge ACLK);
      check_output("idle_awready", 64'(AWREADY), 64'd1);
      check_output("idle_arready", 64'(ARREADY), 64'd0);
      @(posedge ACLK); #1;

      $display("[TB] prefill SRAM words 0..255");
      fill_buffers(255, 1'b1);
      apply_write(8'h01, 32'h0, 255, 2, 1, 0);

      $display("[TB] INCR write/read at 0x10");
      for (int i = 0; i < 4; i++) begin
         wdata_buf[i] = 32'(i + 1);
         wstrb_buf[i] = 4'hF;
      end
      apply_write(8'h11, 32'h10, 3, 2, 1, 2);
      model_read(8'h12, 32'h10, 3, 2, 1);
      set_ar(8'h12, 32'h10, 3, 2, 1);
      ARVALID = 1'b1;
      wait_hs("ar_hs", 3);
      grants++;
      ARVALID = 1'b0;
      @(negedge ACLK);
      check_output("rd_latency_n1", 64'(RVALID), 64'd0);
      @(negedge ACLK);
      check_output("rd_latency_n2", 64'(RVALID), 64'd1);
      @(posedge ACLK); #1;
      r_phase(3, 0);

      $display("[TB] WRAP read at 0x38");
      apply_read(8'h22, 32'h38, 3, 2, 2, 0);

      $display("[TB] simultaneous AW/AR with read stall");
      both_valid(32'h80, 5);
      both_valid(32'h90, 5);
      apply_read(8'h23, 32'h84, 0, 2, 1, 0);
      both_valid(32'hA0, 2);

      $display("[TB] error responses and partial strobes");
      fill_buffers(1, 1'b1);
      bad_last_beat = 0;
      apply_write(8'h31, 32'h40, 1, 2, 1, 0);
      bad_last_beat = -1;
      fill_buffers(3, 1'b1);
      apply_write(8'h32, 32'h50, 3, 2, 3, 1);
      apply_read(8'h33, 32'h50, 3, 2, 3, 0);
      wdata_buf[0] = 32'hFFFF_FFFF; wstrb_buf[0] = 4'hF;
      apply_write(8'h34, 32'h200, 0, 2, 1, 0);
      wdata_buf[0] = 32'h0; wstrb_buf[0] = 4'b0101;
      apply_write(8'h35, 32'h200, 0, 2, 1, 0);
      apply_read(8'h36, 32'h200, 0, 2, 1, 0);
      apply_read(8'h37, 32'h1000, 0, 2, 1, 0);

      $display("[TB] randomized traffic");
      for (int t = 0; t < 40; t++) begin
         int len, size, burst, pick;
         logic [31:0] addr = 32'($urandom_range(0, 32'h2FF));
         logic [7:0]  id   = 8'($urandom);
         pick  = $urandom_range(0, 5);
         len   = (pick == 5) ? $urandom_range(0, 15) : ((1 << pick) - 1);
         size  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
         burst = $urandom_range(0, 3);
         if ($urandom_range(0, 1) == 0) begin
            fill_buffers(len, $urandom_range(0, 2) == 0);
            bad_last_beat = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
            apply_write(id, addr, len, size, burst, $urandom_range(0, 3));
            bad_last_beat = -1;
         end else begin
            apply_read(id, addr, len, size, burst, ($urandom_range(0, 3) == 0) ? 2 : 0);
         end
      end

      $display("[TB] reset in the middle of a read burst");
      model_read(8'h44, 32'h100, 3, 2, 1);
      set_ar(8'h44, 32'h100, 3, 2, 1);
      ARVALID = 1'b1;
      wait_hs("ar_hs", 3);
      ARVALID = 1'b0;
      RREADY = 1'b1;
      cnt = 0;
      while (cnt < 2) begin
         @(negedge ACLK);
         if (RVALID && RREADY) cnt++;
         else if (cnt == 0 && !RVALID) cnt = cnt;
      end
      @(posedge ACLK); #1;
      RREADY = 1'b0;
      repeat (2) begin @(posedge ACLK); #1; end
      ARESETn = 1'b0;
      #1;
      check_reset_outputs("midrst");
      rq.delete();
      grants = 0;
      @(posedge ACLK); #1;
      ARESETn = 1'b1;
      @(posedge ACLK); #1;
      apply_read(8'h45, 32'h104, 1, 2, 1, 0);
      both_valid(32'hC0, 1);

      repeat (3) @(posedge ACLK);
      check_output("bq_drained", 64'(bq.size()), 64'd0);
      check_output("rq_drained", 64'(rq.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute bound in case a wait outside the handshake helpers never returns
   initial begin
      #900000;
      timeout_fail("global_watchdog");
   end

endmodule
